uart_packet_buffer: RTL and testbench
=====================================

// Module: uart_packet_buffer
// PURPOSE
//   Stage directly downstream of the UART deserializer. Captures each validated byte
//   (uart_word qualified by the deserializer's ready pulse) and frames bytes into packets:
//   [LEN][PAYLOAD x LEN]. Stores the payload, then presents it to the BPSK modulator as a
//   valid/ready byte stream with an end-of-packet marker. Single-packet store; no overlap.
// PARAMETERS
//   MAX_LEN  64                  largest accepted payload length in bytes (1..255)
//   ADDR_W   $clog2(MAX_LEN)     payload memory index width
// PORTS
//   clk_baud   in   1       baud-rate clock; the only clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   uart_word  in   8       byte from deserializer, stable while uart_ready=1
//   uart_ready in   1       deserializer byte-valid level (may stay high >1 cycle)
//   out_byte   out  8       payload byte to modulator
//   out_valid  out  1       out_byte valid
//   out_ready  in   1       modulator accepts out_byte this cycle
//   out_last   out  1       out_byte is final payload byte (qualified by out_valid)
//   busy       out  1       packet in progress (S_PAYLOAD, S_CHECK or S_DRAIN)
//   overrun    out  1       sticky: byte arrived while draining and was dropped
//   pkt_error  out  1       one-cycle pulse: framing/length/checksum error
// BEHAVIOUR
//   - Byte capture: byte_stb = uart_ready & ~ready_q; ready_q registered each cycle.
//     ready_q resets to 1, so a level high at reset release is not a byte. One byte per
//     rising edge of uart_ready regardless of how long it stays high.
//   - Reset: state=S_LEN, out_valid=0, out_last=0, out_byte=0, busy=0, overrun=0,
//     pkt_error=0, len=0, wr_idx=0, rd_idx=0. Reset mid-packet discards all stored data.
//   - S_LEN: on byte_stb: if 1<=uart_word<=MAX_LEN -> len<=uart_word, wr_idx<=0,
//     -> S_PAYLOAD; else pkt_error pulse, stay S_LEN (0 or >MAX_LEN rejected).
//   - S_PAYLOAD: on byte_stb: mem[wr_idx]<=uart_word, wr_idx++; on byte len-1 ->
//     S_DRAIN (or S_CHECK when checksum is compiled in). wr_idx never exceeds len-1.
//   - S_DRAIN: out_valid=1, out_byte=mem[rd_idx] (async read), out_last=(rd_idx==len-1).
//     Transfer when out_valid&out_ready: rd_idx++. Transfer with out_last -> S_LEN,
//     rd_idx<=0; out_valid low the following cycle. out_byte/out_last held stable
//     while out_valid&~out_ready.
//   - Latency: out_valid rises the cycle after the final payload byte's byte_stb
//     (after the checksum byte's byte_stb when compiled in).
//   - byte_stb in S_DRAIN: byte dropped, overrun<=1 (cleared only by rst).
//   - pkt_error is registered: high exactly one cycle after the offending byte_stb.
//   - busy = (state != S_LEN).
// CONFIGURATION
//   UART_PKT_CHECKSUM_EN defined: after the payload, S_CHECK takes one extra byte;
//     running XOR of LEN and all payload bytes must equal it. Match -> S_DRAIN;
//     mismatch -> pkt_error pulse, packet discarded, -> S_LEN, no out_valid.
//   Undefined: no S_CHECK; S_PAYLOAD goes straight to S_DRAIN; no checksum logic.
// TESTING
//   T1 bytes 03,A1,B2,C3 (out_ready=1) -> out A1,B2,C3 on 3 consecutive cycles,
//      out_last only with C3, busy low after.
//   T2 uart_ready held high 5 cycles per byte -> each byte captured exactly once.
//   T3 LEN=00 then LEN=MAX_LEN+1 -> two pkt_error pulses, busy stays 0, no output.
//   T4 packet 02,11,22 with out_ready=0 for 10 cycles, then send 55 -> out_byte=11
//      held stable, overrun=1, then 11,22 delivered; 55 never output.
//   T5 rst asserted after LEN=04 and 2 payload bytes -> all outputs at reset values;
//      next packet 01,7E delivers 7E with out_last=1.
//   T6 (UART_PKT_CHECKSUM_EN) 02,10,20,32 -> delivers 10,20; 02,10,20,33 -> pkt_error,
//      no out_valid.

Source files
------------

// File: rtl/uart_packet_buffer.sv
// Frames deserialized UART bytes as [LEN][PAYLOAD x LEN] and replays the payload as a
// valid/ready byte stream. Optional trailing XOR checksum byte: define UART_PKT_CHECKSUM_EN.
module uart_packet_buffer #(
   parameter int MAX_LEN = 64,
   parameter int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic       clk_baud,
   input  logic       rst,
   input  logic [7:0] uart_word,
   input  logic       uart_ready,
   output logic [7:0] out_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       overrun,
   output logic       pkt_error
);

`ifdef UART_PKT_CHECKSUM_EN
   typedef enum logic [1:0] {S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;
`else
   typedef enum logic [1:0] {S_LEN, S_PAYLOAD, S_DRAIN} state_t;
`endif

   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

   state_t            state_reg, state_next;
   logic [7:0]        len_reg, len_next;
   logic [ADDR_W-1:0] wr_idx_reg, wr_idx_next;
   logic [ADDR_W-1:0] rd_idx_reg, rd_idx_next;
   logic              overrun_reg, overrun_next;
   logic              pkt_error_reg, pkt_error_next;
   logic              ready_q_reg;
   logic              mem_we;
   logic              byte_stb;
   logic              wr_last;
   logic              rd_last;
   logic [7:0]        mem [MAX_LEN];
`ifdef UART_PKT_CHECKSUM_EN
   logic [7:0]        csum_reg, csum_next;
`endif

   // ready_q starts high so a level already present at reset release is not a byte
   assign byte_stb = uart_ready & ~ready_q_reg;
   assign wr_last  = (8'(wr_idx_reg) == (len_reg - 8'd1));
   assign rd_last  = (8'(rd_idx_reg) == (len_reg - 8'd1));

   assign busy      = (state_reg != S_LEN);
   assign out_valid = (state_reg == S_DRAIN);
   assign out_last  = out_valid & rd_last;
   assign out_byte  = out_valid ? mem[rd_idx_reg] : 8'h00;
   assign overrun   = overrun_reg;
   assign pkt_error = pkt_error_reg;

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      wr_idx_next    = wr_idx_reg;
      rd_idx_next    = rd_idx_reg;
      overrun_next   = overrun_reg;
      pkt_error_next = 1'b0;
      mem_we         = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
      csum_next      = csum_reg;
`endif
      case (state_reg)
         S_LEN: begin
            if (byte_stb) begin
               if ((uart_word != 8'd0) && (uart_word <= MAX_LEN8)) begin
                  len_next    = uart_word;
                  wr_idx_next = '0;
                  state_next  = S_PAYLOAD;
`ifdef UART_PKT_CHECKSUM_EN
                  csum_next   = uart_word;
`endif
               end else begin
                  pkt_error_next = 1'b1;
               end
            end
         end
         S_PAYLOAD: begin
            if (byte_stb) begin
               mem_we = 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
               csum_next = csum_reg ^ uart_word;
               if (wr_last) state_next = S_CHECK;
`else
               if (wr_last) state_next = S_DRAIN;
`endif
               else wr_idx_next = wr_idx_reg + ADDR_W'(1);
            end
         end
`ifdef UART_PKT_CHECKSUM_EN
         S_CHECK: begin
            if (byte_stb) begin
               if (uart_word == csum_reg) begin
                  state_next = S_DRAIN;
               end else begin
                  pkt_error_next = 1'b1;
                  state_next     = S_LEN;
               end
            end
         end
`endif
         S_DRAIN: begin
            // the store holds one packet only, so anything arriving now is lost
            if (byte_stb) overrun_next = 1'b1;
            if (out_ready) begin
               if (rd_last) begin
                  rd_idx_next = '0;
                  state_next  = S_LEN;
               end else begin
                  rd_idx_next = rd_idx_reg + ADDR_W'(1);
               end
            end
         end
         default: state_next = S_LEN;
      endcase
   end

   always_ff @(posedge clk_baud) begin
      if (rst) begin
         state_reg     <= S_LEN;
         len_reg       <= 8'd0;
         wr_idx_reg    <= '0;
         rd_idx_reg    <= '0;
         overrun_reg   <= 1'b0;
         pkt_error_reg <= 1'b0;
         ready_q_reg   <= 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
         csum_reg      <= 8'd0;
`endif
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         wr_idx_reg    <= wr_idx_next;
         rd_idx_reg    <= rd_idx_next;
         overrun_reg   <= overrun_next;
         pkt_error_reg <= pkt_error_next;
         ready_q_reg   <= uart_ready;
`ifdef UART_PKT_CHECKSUM_EN
         csum_reg      <= csum_next;
`endif
      end
   end

   always_ff @(posedge clk_baud) begin
      if (mem_we) mem[wr_idx_reg] <= uart_word;
   end

endmodule

// File: tb/tb_uart_packet_buffer.sv
// Directed bench for uart_packet_buffer; one task per scenario, inline checks.
// Define UART_PKT_CHECKSUM_EN for both bench and RTL to exercise the checksum build.
module tb_uart_packet_buffer;

   localparam int MAX_LEN = 64;

   logic       clk_baud = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] uart_word = 8'h00;
   logic       uart_ready = 1'b0;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_last;
   logic       busy;
   logic       overrun;
   logic       pkt_error;

   int         checks_total = 0;
   int         checks_passed = 0;
   logic [8:0] mon_q [$];
   logic [7:0] pkt_buf [0:255];

   uart_packet_buffer #(.MAX_LEN(MAX_LEN)) dut (
      .clk_baud  (clk_baud),
      .rst       (rst),
      .uart_word (uart_word),
      .uart_ready(uart_ready),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .overrun   (overrun),
      .pkt_error (pkt_error)
   );

   always #5 clk_baud = ~clk_baud;

   // Records every accepted output byte, sampled mid-low-phase before the transfer edge
   always @(negedge clk_baud) begin
      #2;
      if (out_valid && out_ready) begin
         mon_q.push_back({out_last, out_byte});
         $display("out byte=%h last=%b", out_byte, out_last);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk_baud);
      uart_word  = b;
      uart_ready = 1'b1;
      repeat (hold) @(negedge clk_baud);
      uart_ready = 1'b0;
   endtask

   // Sends pkt_buf[0..n-1] (LEN first), plus the XOR checksum in the checksum build
   task automatic send_pkt(input int n, input int hold);
      logic [7:0] cs;
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
         cs ^= pkt_buf[i];
         send_byte(pkt_buf[i], hold);
      end
`ifdef UART_PKT_CHECKSUM_EN
      send_byte(cs, hold);
`endif
   endtask

   task automatic test_reset;
      rst = 1'b1; uart_word = 8'h05; uart_ready = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk_baud);
      rst = 1'b0;
      repeat (3) @(negedge clk_baud);
      #1;
      checks_total++; if (busy !== 1'b0) $display("FAIL reset_level_busy: got %b expected 0", busy); else checks_passed++;
      checks_total++; if (pkt_error !== 1'b0) $display("FAIL reset_level_err: got %b expected 0", pkt_error); else checks_passed++;
      uart_ready = 1'b0;
      checks_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else checks_passed++;
      checks_total++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", out_last); else checks_passed++;
      checks_total++; if (out_byte !== 8'h00) $display("FAIL reset_byte: got %h expected 00", out_byte); else checks_passed++;
      checks_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else checks_passed++;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      pkt_buf[0] = 8'h03; pkt_buf[1] = 8'hA1; pkt_buf[2] = 8'hB2; pkt_buf[3] = 8'hC3;
      send_pkt(4, 1);
      #1;
      checks_total++; if (out_valid !== 1'b1) $display("FAIL t1_valid0: got %b expected 1", out_valid); else checks_passed++;
      checks_total++; if (out_byte !== 8'hA1) $display("FAIL t1_byte0: got %h expected a1", out_byte); else checks_passed++;
      checks_total++; if (out_last !== 1'b0) $display("FAIL t1_last0: got %b expected 0", out_last); else checks_passed++;
      checks_total++; if (busy !== 1'b1) $display("FAIL t1_busy: got %b expected 1", busy); else checks_passed++;
      @(negedge clk_baud); #1;
      checks_total++; if (out_byte !== 8'hB2) $display("FAIL t1_byte1: got %h expected b2", out_byte); else checks_passed++;
      checks_total++; if (out_last !== 1'b0) $display("FAIL t1_last1: got %b expected 0", out_last); else checks_passed++;
      @(negedge clk_baud); #1;
      checks_total++; if (out_byte !== 8'hC3) $display("FAIL t1_byte2: got %h expected c3", out_byte); else checks_passed++;
      checks_total++; if (out_last !== 1'b1) $display("FAIL t1_last2: got %b expected 1", out_last); else checks_passed++;
      @(negedge clk_baud); #1;
      checks_total++; if (out_valid !== 1'b0) $display("FAIL t1_valid_after: got %b expected 0", out_valid); else checks_passed++;
      checks_total++; if (busy !== 1'b0) $display("FAIL t1_busy_after: got %b expected 0", busy); else checks_passed++;
   endtask

   task automatic test_held_ready;
      mon_q.delete();
      pkt_buf[0] = 8'h02; pkt_buf[1] = 8'h5A; pkt_buf[2] = 8'hA5;
      send_pkt(3, 5);
      repeat (3) @(negedge clk_baud);
      #1;
      checks_total++; if (mon_q.size() !== 2) $display("FAIL t2_count: got %0d expected 2", mon_q.size()); else checks_passed++;
      checks_total++; if (mon_q[0] !== 9'h05A) $display("FAIL t2_out0: got %h expected 05a", mon_q[0]); else checks_passed++;
      checks_total++; if (mon_q[1] !== 9'h1A5) $display("FAIL t2_out1: got %h expected 1a5", mon_q[1]); else checks_passed++;
      checks_total++; if (overrun !== 1'b0) $display("FAIL t2_overrun: got %b expected 0", overrun); else checks_passed++;
      checks_total++; if (busy !== 1'b0) $display("FAIL t2_busy: got %b expected 0", busy); else checks_passed++;
   endtask

   task automatic test_bad_len;
      logic [7:0] lens [2];
      lens[0] = 8'h00;
      lens[1] = 8'(MAX_LEN + 1);
      mon_q.delete();
      for (int k = 0; k < 2; k++) begin
         send_byte(lens[k], 1);
         #1;
         checks_total++; if (pkt_error !== 1'b1) $display("FAIL t3_err_pulse%0d: got %b expected 1", k, pkt_error); else checks_passed++;
         checks_total++; if (busy !== 1'b0) $display("FAIL t3_busy%0d: got %b expected 0", k, busy); else checks_passed++;
         @(negedge clk_baud); #1;
         checks_total++; if (pkt_error !== 1'b0) $display("FAIL t3_err_end%0d: got %b expected 0", k, pkt_error); else checks_passed++;
      end
      repeat (3) @(negedge clk_baud);
      checks_total++; if (mon_q.size() !== 0) $display("FAIL t3_no_output: got %0d bytes expected 0", mon_q.size()); else checks_passed++;
   endtask

   task automatic test_stall;
      logic stable;
      mon_q.delete();
      out_ready = 1'b0;
      pkt_buf[0] = 8'h02; pkt_buf[1] = 8'h11; pkt_buf[2] = 8'h22;
      send_pkt(3, 1);
      #1;
      checks_total++; if (out_byte !== 8'h11) $display("FAIL t4_first: got %h expected 11", out_byte); else checks_passed++;
      send_byte(8'h55, 1);
      #1;
      checks_total++; if (overrun !== 1'b1) $display("FAIL t4_overrun: got %b expected 1", overrun); else checks_passed++;
      stable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_baud); #1;
         if (out_byte !== 8'h11 || out_valid !== 1'b1 || out_last !== 1'b0) stable = 1'b0;
      end
      checks_total++; if (stable !== 1'b1) $display("FAIL t4_hold: byte %h valid %b not held, expected 11/1", out_byte, out_valid); else checks_passed++;
      out_ready = 1'b1;
      repeat (4) @(negedge clk_baud);
      #1;
      checks_total++; if (mon_q.size() !== 2) $display("FAIL t4_count: got %0d expected 2", mon_q.size()); else checks_passed++;
      checks_total++; if (mon_q[0] !== 9'h011) $display("FAIL t4_out0: got %h expected 011", mon_q[0]); else checks_passed++;
      checks_total++; if (mon_q[1] !== 9'h122) $display("FAIL t4_out1: got %h expected 122", mon_q[1]); else checks_passed++;
      checks_total++; if (overrun !== 1'b1) $display("FAIL t4_sticky: got %b expected 1", overrun); else checks_passed++;
   endtask

   task automatic test_mid_reset;
      out_ready = 1'b1;
      send_byte(8'h04, 1);
      send_byte(8'hAA, 1);
      send_byte(8'hBB, 1);
      @(negedge clk_baud); rst = 1'b1;
      @(negedge clk_baud); rst = 1'b0;
      #1;
      checks_total++; if (busy !== 1'b0) $display("FAIL t5_busy: got %b expected 0", busy); else checks_passed++;
      checks_total++; if (out_valid !== 1'b0) $display("FAIL t5_valid: got %b expected 0", out_valid); else checks_passed++;
      checks_total++; if (out_byte !== 8'h00) $display("FAIL t5_byte: got %h expected 00", out_byte); else checks_passed++;
      checks_total++; if (overrun !== 1'b0) $display("FAIL t5_overrun: got %b expected 0", overrun); else checks_passed++;
      mon_q.delete();
      pkt_buf[0] = 8'h01; pkt_buf[1] = 8'h7E;
      send_pkt(2, 1);
      #1;
      checks_total++; if (out_byte !== 8'h7E) $display("FAIL t5_new_byte: got %h expected 7e", out_byte); else checks_passed++;
      checks_total++; if (out_last !== 1'b1) $display("FAIL t5_new_last: got %b expected 1", out_last); else checks_passed++;
      @(negedge clk_baud); #1;
      checks_total++; if (out_valid !== 1'b0) $display("FAIL t5_valid_after: got %b expected 0", out_valid); else checks_passed++;
      checks_total++; if (mon_q.size() !== 1) $display("FAIL t5_count: got %0d expected 1", mon_q.size()); else checks_passed++;
   endtask

   task automatic test_max_len;
      logic [8:0] exp;
      mon_q.delete();
      pkt_buf[0] = 8'(MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) pkt_buf[i + 1] = 8'(i) ^ 8'h3C;
      send_pkt(MAX_LEN + 1, 1);
      repeat (MAX_LEN + 4) @(negedge clk_baud);
      checks_total++; if (mon_q.size() !== MAX_LEN) $display("FAIL tmax_count: got %0d expected %0d", mon_q.size(), MAX_LEN); else checks_passed++;
      for (int i = 0; i < MAX_LEN && i < mon_q.size(); i++) begin
         exp = {(i == MAX_LEN - 1), 8'(i) ^ 8'h3C};
         checks_total++; if (mon_q[i] !== exp) $display("FAIL tmax_out%0d: got %h expected %h", i, mon_q[i], exp); else checks_passed++;
      end
   endtask

   task automatic test_back_to_back;
      mon_q.delete();
      pkt_buf[0] = 8'h01; pkt_buf[1] = 8'h99;
      send_pkt(2, 1);
      pkt_buf[0] = 8'h02; pkt_buf[1] = 8'h01; pkt_buf[2] = 8'h02;
      send_pkt(3, 1);
      repeat (4) @(negedge clk_baud);
      checks_total++; if (mon_q.size() !== 3) $display("FAIL tb2b_count: got %0d expected 3", mon_q.size()); else checks_passed++;
      checks_total++; if (mon_q[0] !== 9'h199) $display("FAIL tb2b_out0: got %h expected 199", mon_q[0]); else checks_passed++;
      checks_total++; if (mon_q[2] !== 9'h102) $display("FAIL tb2b_out2: got %h expected 102", mon_q[2]); else checks_passed++;
      checks_total++; if (overrun !== 1'b0) $display("FAIL tb2b_overrun: got %b expected 0", overrun); else checks_passed++;
   endtask

`ifdef UART_PKT_CHECKSUM_EN
   task automatic test_checksum;
      mon_q.delete();
      send_byte(8'h02, 1); send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h32, 1);
      repeat (3) @(negedge clk_baud);
      checks_total++; if (mon_q.size() !== 2) $display("FAIL t6_good_count: got %0d expected 2", mon_q.size()); else checks_passed++;
      checks_total++; if (mon_q[0] !== 9'h010) $display("FAIL t6_good_out0: got %h expected 010", mon_q[0]); else checks_passed++;
      checks_total++; if (mon_q[1] !== 9'h120) $display("FAIL t6_good_out1: got %h expected 120", mon_q[1]); else checks_passed++;
      mon_q.delete();
      send_byte(8'h02, 1); send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h33, 1);
      #1;
      checks_total++; if (pkt_error !== 1'b1) $display("FAIL t6_bad_err: got %b expected 1", pkt_error); else checks_passed++;
      checks_total++; if (out_valid !== 1'b0) $display("FAIL t6_bad_valid: got %b expected 0", out_valid); else checks_passed++;
      repeat (3) @(negedge clk_baud);
      checks_total++; if (mon_q.size() !== 0) $display("FAIL t6_bad_count: got %0d expected 0", mon_q.size()); else checks_passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_held_ready();
      test_bad_len();
      test_stall();
      test_mid_reset();
      test_max_len();
      test_back_to_back();
`ifdef UART_PKT_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
